gray_conv_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one binary-to-Gray conversion datapath among `N_REQ` requesters. Each requester presents a binary word with a valid/ready handshake. The block picks one requester per cycle, converts the word with `gray = bin ^ (bin >> 1)`, and holds the result in a single output register with a valid/ready handshake. It sits between multiple producers (pointer/counter logic) and the shared Gray encoder used for clock-domain-safe transfer.

---
 rtl/gray_conv_arb.sv | 156 +++++++++++++++
 tb/tb_gray_conv_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arb.sv
// ---------------------------------------------------------------------------
// gray_conv_arb
//
// Round-robin arbiter in front of a single shared binary-to-Gray converter.
// N_REQ producers each offer a binary word on a valid/ready handshake. At
// most one is accepted per cycle. Its word is converted with
// gray = bin ^ (bin >> 1) and captured in one output register, which is
// drained through its own valid/ready handshake.
//
// Parameters
//   WIDTH  data width of request words and results
//   N_REQ  number of requesters (2..16)
//   ID_W   width of the requester index, 2**ID_W >= N_REQ
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   req_valid  [N_REQ]        requester i offers a word
//   req_data   [N_REQ*WIDTH]  word of requester i at [i*WIDTH +: WIDTH]
//   req_ready  [N_REQ]        one-hot grant (or zero), combinational
//   out_valid                 result register holds a result
//   out_ready                 consumer takes the result this cycle
//   out_gray   [WIDTH]        Gray-coded result
//   out_bin    [WIDTH]        original binary word
//   out_id     [ID_W]         index of the requester that produced it
//   grant_cnt  [16]           accept counter, wraps at 0xFFFF
//                             (present only with GRAY_CONV_ARB_STAT_EN)
//
// Build option
//   GRAY_CONV_ARB_STAT_EN  when defined, adds the grant_cnt port/counter.
// ---------------------------------------------------------------------------
module gray_conv_arb #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_gray,
    output logic [WIDTH-1:0]       out_bin,
    output logic [ID_W-1:0]        out_id
`ifdef GRAY_CONV_ARB_STAT_EN
    ,
    output logic [15:0]            grant_cnt
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;

    logic             can_accept;
    logic [N_REQ-1:0] ptr_mask;
    logic [N_REQ-1:0] masked_valid;
    logic [N_REQ-1:0] upper_oh;
    logic [N_REQ-1:0] lowest_oh;
    logic [N_REQ-1:0] pick_oh;
    logic             grant_en;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [ID_W-1:0]  next_ptr;

    assign out_valid  = (state == S_FULL);
    assign can_accept = !out_valid || out_ready;

    // Requesters at or above rr_ptr take priority; if none of them is
    // valid the scan wraps and the lowest valid index wins.
    for (genvar i = 0; i < N_REQ; i++) begin : g_mask
        assign ptr_mask[i] = (ID_W'(i) >= rr_ptr);
    end

    assign masked_valid = req_valid & ptr_mask;
    // x & -x isolates the lowest set bit.
    assign upper_oh     = masked_valid & (-masked_valid);
    assign lowest_oh    = req_valid & (-req_valid);
    assign pick_oh      = (masked_valid != '0) ? upper_oh : lowest_oh;

    // Gated by rst_n so nothing is handed out while reset is held.
    assign grant_en  = rst_n && can_accept && (req_valid != '0);
    assign req_ready = grant_en ? pick_oh : '0;

    // One-hot to index encode and data select as an AND-OR mux.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                grant_idx  = grant_idx | ID_W'(i);
                grant_data = grant_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The pointer wraps at N_REQ, not at 2**ID_W, so unused index codes are
    // never visited when N_REQ is not a power of two.
    assign next_ptr = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples the pre-edge values of all others.
        if (!rst_n) begin
            // NOTE: the result datapath is reset as well as the control,
            // so a result held at reset is discarded and reads back as 0.
            state    <= S_EMPTY;
            out_gray <= '0;
            out_bin  <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
`ifdef GRAY_CONV_ARB_STAT_EN
            grant_cnt <= '0;
`endif
        end else begin
            case (state)
                S_EMPTY: begin
                    if (grant_en) begin
                        state    <= S_FULL;
                        out_bin  <= grant_data;
                        out_gray <= grant_data ^ (grant_data >> 1);
                        out_id   <= grant_idx;
                        rr_ptr   <= next_ptr;
                    end
                end
                S_FULL: begin
                    // A consume and a new grant on the same edge reload the
                    // register directly, giving one result per cycle.
                    if (grant_en) begin
                        out_bin  <= grant_data;
                        out_gray <= grant_data ^ (grant_data >> 1);
                        out_id   <= grant_idx;
                        rr_ptr   <= next_ptr;
                    end else if (out_ready) begin
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
`ifdef GRAY_CONV_ARB_STAT_EN
            if (grant_en) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gray_conv_arb.sv
// ---------------------------------------------------------------------------
// tb_gray_conv_arb
//
// Directed vector table (reset, single request, wrap, round robin,
// backpressure, reset mid-stall, consume without grant) followed by a
// random soak against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_gray_conv_arb;

    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_gray;
    logic [WIDTH-1:0]       out_bin;
    logic [ID_W-1:0]        out_id;
`ifdef GRAY_CONV_ARB_STAT_EN
    logic [15:0]            grant_cnt;
`endif

    gray_conv_arb #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id)
`ifdef GRAY_CONV_ARB_STAT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs for one cycle, req_ready expected before the
    // edge, registered outputs expected after it.
    typedef struct {
        string        name;
        logic         rst;
        logic [3:0]   valid;
        logic [127:0] data;
        logic         ordy;
        logic [3:0]   exp_rdy;
        logic         exp_ov;
        logic [31:0]  exp_gray;
        logic [31:0]  exp_bin;
        logic [1:0]   exp_id;
    } vec_t;

    function automatic vec_t mk(string name, logic r, logic [3:0] v, logic [127:0] d,
                                logic o, logic [3:0] rdy, logic ov, logic [31:0] g,
                                logic [31:0] b, logic [1:0] id);
        vec_t t;
        t.name = name; t.rst = r; t.valid = v; t.data = d; t.ordy = o;
        t.exp_rdy = rdy; t.exp_ov = ov; t.exp_gray = g; t.exp_bin = b; t.exp_id = id;
        return t;
    endfunction

    // Reference arbiter: first valid index at or after ptr, wrapping at N_REQ.
    function automatic int pick(logic [N_REQ-1:0] v, int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (ptr + k) % N_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic [ID_W-1:0]  id;
    } xact_t;

    localparam logic [127:0] D_RR     = {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [127:0] D_SINGLE = {32'h0, 32'hF, 32'h0, 32'h0};
    localparam logic [127:0] D_FF     = {96'h0, 32'hFFFF_FFFF};
    localparam logic [127:0] D_FIVE   = {32'h0, 32'h5, 64'h0};

    initial begin
        vec_t  tbl[$];
        xact_t q[$];
        int    m_ptr;
        bit    m_ov;
        int    accepted;
        int    consumed;
        int    cyc;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        //                  name       rst valid  data      ordy rdy     ov  gray          bin           id
        tbl.push_back(mk("reset0",     0, 4'hF, D_RR,     0, 4'h0, 0, 32'h0,        32'h0,        2'd0));
        tbl.push_back(mk("reset1",     0, 4'hF, D_RR,     0, 4'h0, 0, 32'h0,        32'h0,        2'd0));
        tbl.push_back(mk("single2",    1, 4'h4, D_SINGLE, 1, 4'h4, 1, 32'h8,        32'hF,        2'd2));
        tbl.push_back(mk("wrap",       1, 4'h3, D_RR,     1, 4'h1, 1, 32'h1,        32'h1,        2'd0));
        tbl.push_back(mk("rr_reset",   0, 4'hF, D_RR,     1, 4'h0, 0, 32'h0,        32'h0,        2'd0));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk("rr0",    1, 4'hF, D_RR,     1, 4'h1, 1, 32'h1,        32'h1,        2'd0));
            tbl.push_back(mk("rr1",    1, 4'hF, D_RR,     1, 4'h2, 1, 32'h3,        32'h2,        2'd1));
            tbl.push_back(mk("rr2",    1, 4'hF, D_RR,     1, 4'h4, 1, 32'h2,        32'h3,        2'd2));
            tbl.push_back(mk("rr3",    1, 4'hF, D_RR,     1, 4'h8, 1, 32'h6,        32'h4,        2'd3));
        end
        tbl.push_back(mk("bp_load",    1, 4'h1, D_FF,     1, 4'h1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0));
        for (int s = 0; s < 5; s++)
            tbl.push_back(mk("bp_stall", 1, 4'hF, D_RR,   0, 4'h0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0));
        tbl.push_back(mk("bp_release", 1, 4'hF, D_RR,     1, 4'h2, 1, 32'h3,        32'h2,        2'd1));
        tbl.push_back(mk("ms_load",    1, 4'h4, D_FIVE,   1, 4'h4, 1, 32'h7,        32'h5,        2'd2));
        tbl.push_back(mk("ms_stall",   1, 4'h0, D_FIVE,   0, 4'h0, 1, 32'h7,        32'h5,        2'd2));
        tbl.push_back(mk("ms_reset",   0, 4'hF, D_RR,     0, 4'h0, 0, 32'h0,        32'h0,        2'd0));
        tbl.push_back(mk("ms_first",   1, 4'h6, D_RR,     1, 4'h2, 1, 32'h3,        32'h2,        2'd1));
        tbl.push_back(mk("drain",      1, 4'h0, D_RR,     1, 4'h0, 0, 32'h3,        32'h2,        2'd1));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            rst_n     = tbl[i].rst;
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("%s req_ready", tbl[i].name), 128'(req_ready), 128'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("%s out_valid", tbl[i].name), 128'(out_valid), 128'(tbl[i].exp_ov));
            check($sformatf("%s out_gray",  tbl[i].name), 128'(out_gray),  128'(tbl[i].exp_gray));
            check($sformatf("%s out_bin",   tbl[i].name), 128'(out_bin),   128'(tbl[i].exp_bin));
            check($sformatf("%s out_id",    tbl[i].name), 128'(out_id),    128'(tbl[i].exp_id));
        end

        // Random soak: reset, then compare against the reference model.
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_ov     = 1'b0;
        accepted = 0;
        consumed = 0;
        cyc      = 0;
`ifdef GRAY_CONV_ARB_STAT_EN
        check("grant_cnt reset", 128'(grant_cnt), 128'(0));
`endif
        while (accepted < 10000 && cyc < 40000) begin
            int          g;
            bit          can;
            logic [3:0]  exp_rdy;
            xact_t       t;
            cyc++;
            req_valid = 4'($urandom_range(0, 15));
            req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 15) == 0) req_data[31:0] = 32'hFFFF_FFFF;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            can     = !m_ov || out_ready;
            g       = (can && req_valid != '0) ? pick(req_valid, m_ptr) : -1;
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            check("soak req_ready", 128'(req_ready), 128'(exp_rdy));
            check("soak out_valid", 128'(out_valid), 128'(m_ov));
            if (m_ov && out_ready) begin
                if (q.size() == 0) begin
                    check("soak underflow", 128'(0), 128'(1));
                end else begin
                    t = q.pop_front();
                    check("soak out_bin",  128'(out_bin),  128'(t.bin));
                    check("soak out_gray", 128'(out_gray), 128'(t.bin ^ (t.bin >> 1)));
                    check("soak out_id",   128'(out_id),   128'(t.id));
                    consumed++;
                end
            end
            if (g >= 0) begin
                t.bin = req_data[g*WIDTH +: WIDTH];
                t.id  = ID_W'(g);
                q.push_back(t);
                m_ptr = (g + 1) % N_REQ;
                m_ov  = 1'b1;
                accepted++;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        out_ready = 1'b0;
        #1;
        check("soak accepted within budget", 128'(accepted), 128'(10000));
        check("soak held words", 128'(q.size()), 128'(m_ov ? 1 : 0));
        check("soak no loss", 128'(consumed + q.size()), 128'(accepted));
        check("soak final out_valid", 128'(out_valid), 128'(m_ov));
`ifdef GRAY_CONV_ARB_STAT_EN
        check("grant_cnt", 128'(grant_cnt), 128'(accepted % 65536));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
